// File: rtl/grant_scheduler.sv
// Four-requester grant scheduler: arbitrates once per IDLE cycle, then streams the
// granted lane downstream until its last beat or until MAX_BEATS forces a release.
module grant_scheduler #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BEATS  = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic [1:0]              i_mode,
  input  logic [1:0]              i_lock_id,
  input  logic [3:0]              i_valid,
  input  logic [4*DATA_WIDTH-1:0] i_data,
  input  logic [3:0]              i_last,
  output logic [3:0]              o_ready,
  output logic                    o_valid,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic [1:0]              o_id,
  output logic                    o_last,
  input  logic                    i_ready,
  output logic                    o_busy,
  output logic                    o_trunc
);

  localparam int CNT_W = $clog2(MAX_BEATS) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

  typedef enum logic [1:0] {
    MODE_FIXED = 2'd0,
    MODE_RR    = 2'd1,
    MODE_LOCK  = 2'd2,
    MODE_HOLD  = 2'd3
  } mode_e;

  typedef enum logic {
    S_IDLE,
    S_BUSY
  } state_e;

  state_e           state_q, state_d;
  logic [1:0]       id_q, id_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trunc_q, trunc_d;

  logic             win_vld;
  logic [1:0]       win_id;
  logic [1:0]       rr_idx;
  logic             busy;
  logic             xfer;

  assign busy = (state_q == S_BUSY);
  assign xfer = busy && i_valid[id_q] && i_ready;

  // Winner selection. Loops run from the least to the most preferred candidate so
  // the last hit standing is the winner.
  // NOTE: every signal assigned in an always_comb gets a default at the top; a
  // path that skips an assignment would otherwise infer a latch.
  always_comb begin
    win_vld = 1'b0;
    win_id  = 2'd0;
    rr_idx  = 2'd0;
    case (i_mode)
      MODE_FIXED: begin
        for (int k = 3; k >= 0; k--) begin
          if (i_valid[k]) begin
            win_vld = 1'b1;
            win_id  = 2'(k);
          end
        end
      end
      MODE_RR: begin
        for (int k = 4; k >= 1; k--) begin
          rr_idx = ptr_q + 2'(k);
          if (i_valid[rr_idx]) begin
            win_vld = 1'b1;
            win_id  = rr_idx;
          end
        end
      end
      MODE_LOCK: begin
        if (i_valid[i_lock_id]) begin
          win_vld = 1'b1;
          win_id  = i_lock_id;
        end
      end
      default: begin
        win_vld = 1'b0;
      end
    endcase
  end

  // Downstream mux: only the granted lane is visible, and only while BUSY.
  always_comb begin
    o_ready = 4'b0000;
    o_valid = 1'b0;
    o_data  = '0;
    o_last  = 1'b0;
    if (busy) begin
      o_valid       = i_valid[id_q];
      o_data        = i_data[DATA_WIDTH*id_q +: DATA_WIDTH];
      o_last        = i_last[id_q];
      o_ready[id_q] = i_ready;
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    trunc_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d = S_BUSY;
          id_d    = win_id;
          cnt_d   = '0;
        end
      end
      S_BUSY: begin
        if (xfer) begin
          cnt_d = cnt_q + 1'b1;
          // A genuine last beat wins over the beat limit, so no truncation flag.
          if (i_last[id_q]) begin
            state_d = S_IDLE;
            ptr_d   = id_q;
          end else if (cnt_q == LAST_CNT) begin
            state_d = S_IDLE;
            ptr_d   = id_q;
            trunc_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ptr resets to 3 so the first round-robin search after reset starts at requester 0.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      id_q    <= 2'd0;
      ptr_q   <= 2'd3;
      cnt_q   <= '0;
      trunc_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      trunc_q <= trunc_d;
    end
  end

  assign o_id    = id_q;
  assign o_busy  = busy;
  assign o_trunc = trunc_q;

endmodule

// File: doc/grant_scheduler.md
GRANT_SCHEDULER -- requirements
Module: grant_scheduler

Interface
REQ-001 Parameter DATA_WIDTH, default 8: width of each requester data lane and of o_data.
REQ-002 Parameter MAX_BEATS, default 16, legal 2..256: maximum beats one grant may carry before forced release.
REQ-003 i_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_mode  input  2  arbitration mode: 0 fixed priority, 1 round-robin, 2 locked, 3 hold-off.
REQ-006 i_lock_id  input  2  requester granted in locked mode.
REQ-007 i_valid  input  4  per-requester valid; bit k belongs to requester k.
REQ-008 i_data  input  4*DATA_WIDTH  requester k data in bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 i_last  input  4  per-requester last-beat flag, qualified by i_valid.
REQ-010 o_ready  output  4  per-requester ready.
REQ-011 o_valid  output  1  downstream valid.
REQ-012 o_data  output  DATA_WIDTH  downstream data.
REQ-013 o_id  output  2  id of the currently granted requester.
REQ-014 o_last  output  1  downstream last flag.
REQ-015 i_ready  input  1  downstream ready.
REQ-016 o_busy  output  1  high while a grant is held (state BUSY).
REQ-017 o_trunc  output  1  one-cycle pulse when a grant is force-released at MAX_BEATS.

Function
REQ-018 The block SHALL implement a two-state FSM, IDLE and BUSY.
REQ-019 In IDLE, i_mode and i_lock_id are sampled; winner selection is combinational from i_valid.
- mode 0: lowest-index valid requester wins.
- mode 1: first valid requester searching from (ptr+1) mod 4 upward, wrapping.
- mode 2: i_lock_id wins only if i_valid[i_lock_id]=1; else no grant.
- mode 3: no grant.
REQ-020 On a winner in IDLE, the FSM SHALL register o_id=winner, clear the beat counter and enter BUSY next cycle (1-cycle arbitration latency); no transfer occurs in the IDLE cycle.
REQ-021 In IDLE all outputs SHALL be low: o_ready=0, o_valid=0, o_last=0, o_data=0.
REQ-022 In BUSY: o_valid=i_valid[o_id], o_data=lane o_id, o_last=i_last[o_id], o_ready[o_id]=i_ready, every other o_ready bit 0.
REQ-023 A beat transfers when o_valid & i_ready; the beat counter (width ceil(log2(MAX_BEATS))+1) increments per beat.
REQ-024 Transfer with o_last=1: the FSM SHALL return to IDLE next cycle and set ptr=o_id.
REQ-025 Transfer with o_last=0 and counter==MAX_BEATS-1: the FSM SHALL return to IDLE, set ptr=o_id and pulse o_trunc for exactly that next cycle.
REQ-026 If last and MAX_BEATS coincide on the same beat, release is normal: no o_trunc.
REQ-027 Changes to i_mode or i_lock_id during BUSY SHALL have no effect until the next IDLE cycle.
REQ-028 A requester dropping i_valid during BUSY SHALL NOT release the grant; the block waits with o_valid=0.
REQ-029 After release, the earliest next grant is registered in the IDLE cycle, so grants are separated by at least one idle cycle.
REQ-030 Fixed-priority mode SHALL NOT update ptr beyond REQ-024/025 (ptr tracks last grant in every mode).

Reset
REQ-031 While i_rst=1 at a clock edge: state=IDLE, ptr=3, o_id=0, beat counter=0, o_trunc=0, o_busy=0; all outputs follow REQ-021.
REQ-032 Reset asserted mid-BUSY SHALL abandon the grant with no o_trunc; the first post-reset round-robin search starts at requester 0.

Verification
REQ-033 Mode 0, i_valid=4'b1010, each a 1-beat last burst, i_ready=1 -> grants in order id1, id3, each 1 beat, 1 idle cycle between.
REQ-034 Mode 1 after reset, i_valid=4'b1111 held, single-beat bursts -> grant order 0,1,2,3,0; o_busy low one cycle between grants.
REQ-035 Mode 2, i_lock_id=2, i_valid=4'b0001 -> no grant, o_busy=0; set i_valid[2]=1 -> o_id=2 one cycle later.
REQ-036 MAX_BEATS=4, requester 0 sends 6 beats without last -> 4 beats transfer, o_trunc pulses once, requester 0 re-granted in mode 0 after one idle cycle.
REQ-037 Requester 1 granted, i_ready toggles 1,0,1 with 3-beat burst; i_mode switches 0->3 mid-burst -> all 3 beats delivered in order; no grant after release.
REQ-038 i_rst pulsed for one cycle during beat 2 of a burst -> outputs zero next cycle, o_trunc stays 0, ptr=3.
